// File: rtl/mdu_seq_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the mdu_seq multiply/divide sequencer.
package mdu_seq_pkg;

   localparam int INSTR_WIDTH = 32;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   typedef enum logic [2:0] {
      MDU_S_IDLE = 3'd0,
      MDU_S_LOAD = 3'd1,
      MDU_S_CALC = 3'd2,
      MDU_S_FIX  = 3'd3,
      MDU_S_DONE = 3'd4
   } mdu_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   // MULT and DIV are the signed flavours; only honoured when signed support is built in.
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_addsub.sv
// WIDTH+1 bit adder/subtractor shared by the multiply and divide iteration steps.
module mdu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] sum
);

   assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/mdu_seq.sv
// Iterative shift-add multiply / restoring divide sequencer, one bit per cycle.
// Signed MULT/DIV are built only when MDU_SIGNED_EN is defined; otherwise they run unsigned.
//
// state | meaning
// IDLE  | waiting for W_start, operands latched on start
// LOAD  | convert operands to magnitudes, catch divide by zero
// CALC  | WIDTH iterations through the shared add/sub
// FIX   | sign correction, results written to R_hi/R_lo
// DONE  | one-cycle R_done pulse
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int WIDTH = INSTR_WIDTH
) (
   input  logic             W_clk,
   input  logic             W_rst_n,
   input  logic             W_start,
   input  logic [1:0]       W_op,
   input  logic [WIDTH-1:0] W_a,
   input  logic [WIDTH-1:0] W_b,
   input  logic             W_cancel,
   output logic             R_busy,
   output logic             R_done,
   output logic [WIDTH-1:0] R_hi,
   output logic [WIDTH-1:0] R_lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mdu_state_e       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic             is_div, is_sgn, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_sub;
   logic [2*WIDTH-1:0] prod;

   mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .sum (as_sum)
   );

   always_comb begin
      is_div = op_is_div(op_q);
`ifdef MDU_SIGNED_EN
      is_sgn = op_is_signed(op_q);
`else
      is_sgn = 1'b0;
`endif
      a_neg = is_sgn & a_q[WIDTH-1];
      b_neg = is_sgn & b_q[WIDTH-1];
      a_mag = a_neg ? (~a_q + 1'b1) : a_q;
      b_mag = b_neg ? (~b_q + 1'b1) : b_q;
   end

   // Divide: remainder shifted left with the next dividend bit, minus divisor.
   // Multiply: high half plus multiplicand when the current multiplier bit is set.
   always_comb begin
      if (is_div) begin
         as_a   = {hi_q, lo_q[WIDTH-1]};
         as_b   = {1'b0, b_q};
         as_sub = 1'b1;
      end else begin
         as_a   = {1'b0, hi_q};
         as_b   = lo_q[0] ? {1'b0, b_q} : '0;
         as_sub = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      prod      = {hi_q, lo_q};
      if (W_cancel) begin
         state_d = MDU_S_IDLE;
      end else begin
         unique case (state_q)
            MDU_S_IDLE: begin
               if (W_start) begin
                  op_d    = W_op;
                  a_d     = W_a;
                  b_d     = W_b;
                  state_d = MDU_S_LOAD;
               end
            end
            MDU_S_LOAD: begin
               if (is_div && (b_q == '0)) begin
                  res_hi_d = a_q;
                  res_lo_d = '1;
                  state_d  = MDU_S_DONE;
               end else begin
                  hi_d      = '0;
                  lo_d      = a_mag;
                  b_d       = b_mag;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = CW'(WIDTH - 1);
                  state_d   = MDU_S_CALC;
               end
            end
            MDU_S_CALC: begin
               if (is_div) begin
                  hi_d = as_sum[WIDTH] ? as_a[WIDTH-1:0] : as_sum[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], ~as_sum[WIDTH]};
               end else begin
                  hi_d = as_sum[WIDTH:1];
                  lo_d = {as_sum[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) state_d = MDU_S_FIX;
            end
            MDU_S_FIX: begin
               if (is_div) begin
                  res_lo_d = neg_res_q ? (~lo_q + 1'b1) : lo_q;
                  res_hi_d = neg_rem_q ? (~hi_q + 1'b1) : hi_q;
               end else begin
                  if (neg_res_q) prod = ~prod + 1'b1;
                  {res_hi_d, res_lo_d} = prod;
               end
               state_d = MDU_S_DONE;
            end
            MDU_S_DONE: state_d = MDU_S_IDLE;
            default:    state_d = MDU_S_IDLE;
         endcase
      end
      busy_d = (state_d != MDU_S_IDLE) && (state_d != MDU_S_DONE);
      done_d = (state_d == MDU_S_DONE);
   end

   always_ff @(posedge W_clk or negedge W_rst_n) begin
      if (!W_rst_n) begin
         state_q   <= MDU_S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         res_hi_q  <= '0;
         res_lo_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         res_hi_q  <= res_hi_d;
         res_lo_q  <= res_lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign R_busy = busy_q;
   assign R_done = done_q;
   assign R_hi   = res_hi_q;
   assign R_lo   = res_lo_q;

endmodule
